// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings common to the transmitter and
// receiver, plus default framing/oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  // Sample index that lands in the middle of a bit period.
  function automatic int mid_sample(input int oversample);
    return oversample / 2;
  endfunction

  localparam int MID_SAMPLE = mid_sample(OVERSAMPLE_DEFAULT);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer bringing the asynchronous serial line into the CLK
// domain; both flops reset to RESET_VAL so an idle-high line looks idle.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so sync_q takes meta_q's pre-edge value; blocking would collapse the two stages into one.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversamples the synchronized line on clken ticks,
// samples each bit at its midpoint, and hands bytes over with rdy/rdy_clr.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 clken,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS) + 1;
  localparam logic [SCW-1:0] MID_CNT  = SCW'(mid_sample(OVERSAMPLE));
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [SCW-1:0]       sample_cnt_q, sample_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [SCW-1:0]       sample_inc;
  logic                 sample_wrap;
  logic                 stop_ok;
  logic                 stop_bad;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .CLK   (CLK),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign sample_inc  = sample_cnt_q + 1'b1;
  assign sample_wrap = (sample_cnt_q == '1);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      rdy_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      rdy_q        <= rdy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic; only advances on clken ticks.
  always_comb begin
    // NOTE: hold-value defaults first so every path assigns every signal; a missed path would infer a latch.
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    stop_ok      = 1'b0;
    stop_bad     = 1'b0;
    if (clken) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d      = START;
            sample_cnt_d = SCW'(1);
          end
        end
        START: begin
          sample_cnt_d = sample_inc;
          if (sample_inc == MID_CNT) begin
            // Still low at mid start bit: a real start; otherwise a glitch.
            state_d      = rx_s ? IDLE : DATA;
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
          end
        end
        DATA: begin
          sample_cnt_d = sample_inc;
          if (sample_wrap) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) state_d = STOP;
          end
        end
        STOP: begin
          sample_cnt_d = sample_inc;
          if (sample_wrap) begin
            state_d  = IDLE;
            stop_ok  = rx_s;
            stop_bad = !rx_s;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus-side flags; a completing byte overrides a same-cycle rdy_clr.
  always_comb begin
    data_d      = data_q;
    rdy_d       = rdy_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (rdy_clr) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end
    if (stop_ok) begin
      data_d      = shift_q;
      frame_err_d = 1'b0;
      rdy_d       = 1'b1;
      if (rdy_q && !rdy_clr) overrun_d = 1'b1;
    end
    if (stop_bad) frame_err_d = 1'b1;
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != IDLE);

endmodule
